// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader.
// Accepts decoded instruction fields over a valid/ready handshake, packs each
// bundle into a 32-bit MIPS instruction word and writes it to consecutive
// words of instruction memory during a load session. A session is opened by
// start and closed by finish. Illegal op classes are consumed without a write
// and latch a sticky error flag.

module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op_class,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  done,
  output logic                  err_illegal
);

  // DRAIN covers the cycle in which the final write of a session is still
  // on the memory port, so that done only rises once that write has landed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BaseAddrC = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DepthC    = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [5:0] OpcRType = 6'b000000;
  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSw    = 6'b101011;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcAddi  = 6'b001000;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   nextAddr_q, nextAddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    err_q, err_d;

  logic                    fullNow;
  logic                    readyNow;
  logic                    transfer;
  logic                    sessionStart;
  logic                    legal;
  logic [31:0]             encoded;

  assign fullNow      = (count_q == DepthC);
  assign readyNow     = (state_q == LOAD) && !fullNow;
  assign transfer     = in_valid && readyNow;
  assign sessionStart = start && ((state_q == IDLE) || (state_q == DONE));

  // Pack the field bundle into a MIPS word; I-types ignore rd/shamt/funct.
  always_comb begin
    encoded = 32'h0000_0000;
    legal   = 1'b1;
    case (op_class)
      3'd0:    encoded = {OpcRType, rs, rt, rd, shamt, funct};
      3'd1:    encoded = {OpcLw,   rs, rt, imm};
      3'd2:    encoded = {OpcSw,   rs, rt, imm};
      3'd3:    encoded = {OpcBeq,  rs, rt, imm};
      3'd4:    encoded = {OpcAddi, rs, rt, imm};
      default: legal   = 1'b0;
    endcase
  end

  // Session sequencing; finish beats start in LOAD, and a finish that
  // coincides with an accepted bundle waits one cycle for its write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = LOAD;
      LOAD:    if (finish) state_d = transfer ? DRAIN : DONE;
      DRAIN:   state_d = DONE;
      DONE:    if (start)  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Write-port and bookkeeping next-state: one registered write per accepted
  // legal bundle, sticky error for illegal ones, counters cleared by start.
  always_comb begin
    we_d       = 1'b0;
    addr_d     = addr_q;
    nextAddr_d = nextAddr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    err_d      = err_q;
    if (sessionStart) begin
      count_d    = '0;
      err_d      = 1'b0;
      nextAddr_d = BaseAddrC;
    end else if (transfer) begin
      if (legal) begin
        we_d       = 1'b1;
        addr_d     = nextAddr_q;
        wdata_d    = encoded;
        count_d    = count_q + 1'b1;
        nextAddr_d = nextAddr_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset drops any write still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= BaseAddrC;
      nextAddr_q <= BaseAddrC;
      wdata_q    <= 32'h0000_0000;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      nextAddr_q <= nextAddr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign in_ready    = readyNow;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign word_count  = count_q;
  assign full        = fullNow;
  assign done        = (state_q == DONE);
  assign err_illegal = err_q;

endmodule
